// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit.
package lsu_pkg;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  localparam logic [31:0] MEM_BASE_DEFAULT = 32'h0100_0000;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extension: byte/half/word, signed or unsigned.
module load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = data;
    case (size)
      SZ_BYTE: result = {{(XLEN-8){~is_unsigned & data[7]}}, data[7:0]};
      SZ_HALF: result = {{(XLEN-16){~is_unsigned & data[15]}}, data[15:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: IDLE -> ACCESS (one memory cycle) -> RESP handshake to writeback.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] MEM_BASE  = MEM_BASE_DEFAULT,
  parameter int unsigned MEM_DEPTH = 1048576
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [31:0]     in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_rd,
  input  logic [31:0]     in_pc,
  input  logic            flush,
  output logic [31:0]     mem_address,
  output logic [XLEN-1:0] mem_data_in,
  output logic            mem_read_write,
  output logic [1:0]      mem_access_size,
  output logic            mem_is_signed,
  input  logic [XLEN-1:0] mem_data_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_pc,
  output logic            out_wb_en,
  output logic            out_fault
);

  localparam logic [32:0] MEM_LAST = {1'b0, MEM_BASE} + 33'(MEM_DEPTH) - 33'd1;

  state_t          state;
  logic [1:0]      op_reg;
  logic            fault_reg;
  logic [1:0]      req_size;
  logic [32:0]     last_byte;
  logic            out_of_range;
  logic            misaligned;
  logic            is_mem_op;
  logic            req_fault;
  logic            accept;
  logic            load_unsigned;
  logic [XLEN-1:0] load_value;

  assign req_size     = (in_size == 2'b11) ? SZ_WORD : in_size;
  assign last_byte    = {1'b0, in_addr} + 33'(size_bytes(req_size)) - 33'd1;
  assign out_of_range = (in_addr < MEM_BASE) | (last_byte > MEM_LAST);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned   = ((req_size == SZ_HALF) & in_addr[0]) |
                        ((req_size == SZ_WORD) & (in_addr[1:0] != 2'b00));
`else
  assign misaligned   = 1'b0;
`endif
  assign is_mem_op    = (in_op == OP_LOAD) | (in_op == OP_STORE);
  assign req_fault    = is_mem_op & (out_of_range | misaligned);

  assign in_ready = ~flush & ((state == ST_IDLE) | ((state == ST_RESP) & out_ready));
  assign accept   = in_valid & in_ready;

  assign load_unsigned = ~mem_is_signed;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .data        (mem_data_out),
    .size        (mem_access_size),
    .is_unsigned (load_unsigned),
    .result      (load_value)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      op_reg          <= OP_NONE;
      fault_reg       <= 1'b0;
      mem_address     <= '0;
      mem_data_in     <= '0;
      mem_read_write  <= 1'b0;
      mem_access_size <= 2'b00;
      mem_is_signed   <= 1'b0;
      out_valid       <= 1'b0;
      out_result      <= '0;
      out_rd          <= '0;
      out_pc          <= '0;
      out_wb_en       <= 1'b0;
      out_fault       <= 1'b0;
    end else begin
      // The write strobe is a one-cycle pulse; only an accepted store raises it.
      mem_read_write <= 1'b0;
      case (state)
        ST_ACCESS: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            state      <= ST_RESP;
            out_valid  <= 1'b1;
            out_fault  <= fault_reg;
            out_result <= ((op_reg == OP_LOAD) && !fault_reg) ? load_value : '0;
            out_wb_en  <= (op_reg == OP_LOAD) & ~fault_reg & (out_rd != 5'd0);
          end
        end
        ST_RESP: begin
          if (flush || out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      if (accept) begin
        out_rd    <= in_rd;
        out_pc    <= in_pc;
        op_reg    <= is_mem_op ? in_op : OP_NONE;
        fault_reg <= req_fault;
        if (is_mem_op) begin
          state           <= ST_ACCESS;
          out_valid       <= 1'b0;
          mem_address     <= in_addr;
          mem_data_in     <= in_wdata;
          mem_access_size <= req_size;
          mem_is_signed   <= ~in_unsigned;
          mem_read_write  <= (in_op == OP_STORE) & ~req_fault;
        end else begin
          state      <= ST_RESP;
          out_valid  <= 1'b1;
          out_result <= in_addr;
          out_fault  <= 1'b0;
          out_wb_en  <= (in_rd != 5'd0);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized plus directed bench for mem_stage_lsu against a byte-array reference model.
module tb_mem_stage_lsu;

  localparam logic [31:0] MEM_BASE  = 32'h0100_0000;
  localparam int unsigned MEM_DEPTH = 1048576;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_unsigned, flush;
  logic [1:0]  in_op, in_size;
  logic [31:0] in_addr, in_wdata, in_pc;
  logic [4:0]  in_rd;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write, mem_is_signed;
  logic [1:0]  mem_access_size;
  logic        out_valid, out_ready, out_wb_en, out_fault;
  logic [31:0] out_result, out_pc;
  logic [4:0]  out_rd;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;

  logic [7:0] tbmem   [0:1023];
  logic [7:0] ref_mem [0:1023];

  always #5 clock = ~clock;

  mem_stage_lsu #(.XLEN(32), .MEM_BASE(MEM_BASE), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rd(in_rd), .in_pc(in_pc), .flush(flush),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_read_write(mem_read_write), .mem_access_size(mem_access_size),
    .mem_is_signed(mem_is_signed), .mem_data_out(mem_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_pc(out_pc), .out_wb_en(out_wb_en), .out_fault(out_fault)
  );

  // Byte-addressed memory window (low 10 address bits), little-endian.
  always_comb begin
    mem_data_out = {tbmem[10'(mem_address + 32'd3)], tbmem[10'(mem_address + 32'd2)],
                    tbmem[10'(mem_address + 32'd1)], tbmem[10'(mem_address)]};
  end

  always @(posedge clock) begin
    if (mem_read_write) begin
      for (int i = 0; i < ((mem_access_size == 2'd0) ? 1 : (mem_access_size == 2'd1) ? 2 : 4); i++)
        tbmem[10'(mem_address + 32'(i))] <= 8'(mem_data_in >> (8 * i));
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] tb_word(input logic [31:0] a);
    return {tbmem[10'(a + 32'd3)], tbmem[10'(a + 32'd2)], tbmem[10'(a + 32'd1)], tbmem[10'(a)]};
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[10'(a + 32'd3)], ref_mem[10'(a + 32'd2)], ref_mem[10'(a + 32'd1)], ref_mem[10'(a)]};
  endfunction

  task automatic predict(input logic [1:0] op, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [4:0] rd,
                         output logic [31:0] res, output logic flt, output logic wb,
                         output logic we);
    int     nb;
    longint a, lo, hi, v;
    bit     is_mem, bad;
    nb     = nbytes(size);
    a      = longint'(addr);
    lo     = longint'(MEM_BASE);
    hi     = longint'(MEM_BASE) + longint'(MEM_DEPTH) - 1;
    is_mem = (op == 2'd1) || (op == 2'd2);
    bad    = (a < lo) || (a + nb - 1 > hi);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((nb == 2 && a % 2 != 0) || (nb == 4 && a % 4 != 0)) bad = 1'b1;
`endif
    flt = is_mem && bad;
    we  = (op == 2'd2) && !flt;
    wb  = (!is_mem || op == 2'd1) && !flt && (rd != 5'd0);
    if (!is_mem) res = addr;
    else if (op == 2'd2 || flt) res = 32'd0;
    else begin
      v = 0;
      for (int i = 0; i < nb; i++) v += longint'(ref_mem[10'(addr + 32'(i))]) << (8 * i);
      if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
      res = v[31:0];
    end
  endtask

  task automatic model_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    for (int i = 0; i < nbytes(size); i++) ref_mem[10'(addr + 32'(i))] = 8'(wdata >> (8 * i));
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [31:0] pc);
    in_op = op; in_size = size; in_unsigned = uns; in_addr = addr;
    in_wdata = wdata; in_rd = rd; in_pc = pc; in_valid = 1'b1;
  endtask

  // One transaction from IDLE with a fixed expected timeline; hold = cycles WB stalls.
  task automatic run_txn(input string tag, input logic [1:0] op, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input int hold);
    logic [31:0] exp_res, pc;
    logic        exp_flt, exp_wb, exp_we;
    int          w0;
    pc = $urandom;
    predict(op, size, uns, addr, rd, exp_res, exp_flt, exp_wb, exp_we);
    @(negedge clock);
    drive(op, size, uns, addr, wdata, rd, pc);
    out_ready = 1'b0;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    w0 = wr_count;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    if (op == 2'd1 || op == 2'd2) begin
      check({tag, ".acc_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".acc_rw"}, 32'(mem_read_write), 32'(exp_we));
      check({tag, ".acc_addr"}, mem_address, addr);
      @(negedge clock);
    end
    for (int h = 0; h <= hold; h++) begin
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".result"}, out_result, exp_res);
      check({tag, ".fault"}, 32'(out_fault), 32'(exp_flt));
      check({tag, ".wb_en"}, 32'(out_wb_en), 32'(exp_wb));
      check({tag, ".rd_pc"}, {22'd0, out_rd, 5'd0} ^ out_pc, {22'd0, rd, 5'd0} ^ pc);
      if (h < hold) @(negedge clock);
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, ".drop"}, 32'(out_valid), 32'd0);
    check({tag, ".writes"}, 32'(wr_count - w0), 32'(exp_we));
    if (exp_we) begin
      model_store(addr, size, wdata);
      check({tag, ".mem"}, tb_word(addr), ref_word(addr));
    end
  endtask

  initial begin
    logic [31:0] exp_res, a;
    logic        exp_flt, exp_wb, exp_we;
    int          w0, r;
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_op = 2'd0; in_size = 2'd0; in_unsigned = 1'b0; in_addr = '0;
    in_wdata = '0; in_rd = '0; in_pc = '0;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 8'($urandom);
      tbmem[i] <= ref_mem[i];
    end
    repeat (3) @(negedge clock);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.rw", 32'(mem_read_write), 32'd0);
    check("rst.addr", mem_address, 32'd0);
    check("rst.result", out_result, 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;

    // Store then load a word.
    run_txn("t1.st", 2'd2, 2'd2, 1'b0, 32'h0100_0010, 32'hDEAD_BEEF, 5'd0, 0);
    check("t1.memword", tb_word(32'h0100_0010), 32'hDEAD_BEEF);
    run_txn("t1.ld", 2'd1, 2'd2, 1'b0, 32'h0100_0010, 32'h0, 5'd3, 0);

    // Sign/zero extension.
    run_txn("t2.stb", 2'd2, 2'd0, 1'b0, 32'h0100_0020, 32'h1234_5680, 5'd0, 0);
    run_txn("t2.sth", 2'd2, 2'd1, 1'b0, 32'h0100_0022, 32'hABCD_8001, 5'd0, 0);
    run_txn("t2.lbs", 2'd1, 2'd0, 1'b0, 32'h0100_0020, 32'h0, 5'd4, 0);
    run_txn("t2.lbu", 2'd1, 2'd0, 1'b1, 32'h0100_0020, 32'h0, 5'd4, 1);
    run_txn("t2.lhs", 2'd1, 2'd1, 1'b0, 32'h0100_0022, 32'h0, 5'd4, 0);
    run_txn("t2.lhu", 2'd1, 2'd1, 1'b1, 32'h0100_0022, 32'h0, 5'd4, 0);

    // Pass-through held under backpressure, then back-to-back accept.
    @(negedge clock);
    drive(2'd0, 2'd0, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 32'h100);
    @(posedge clock);
    @(negedge clock);
    drive(2'd1, 2'd2, 1'b0, 32'h0100_0010, 32'h0, 5'd7, 32'h104);
    predict(2'd1, 2'd2, 1'b0, 32'h0100_0010, 5'd7, exp_res, exp_flt, exp_wb, exp_we);
    for (int k = 0; k < 3; k++) begin
      check("t3.valid", 32'(out_valid), 32'd1);
      check("t3.result", out_result, 32'h1234_5678);
      check("t3.wb_en", 32'(out_wb_en), 32'd1);
      check("t3.in_ready", 32'(in_ready), 32'd0);
      if (k < 2) @(negedge clock);
    end
    out_ready = 1'b1;
    #1 check("t3.in_ready_rdy", 32'(in_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b0;
    check("t3.b2b_access", 32'(out_valid), 32'd0);
    check("t3.b2b_addr", mem_address, 32'h0100_0010);
    @(negedge clock);
    check("t3.b2b_valid", 32'(out_valid), 32'd1);
    check("t3.b2b_result", out_result, exp_res);
    check("t3.b2b_rd", 32'(out_rd), 32'd7);
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;

    // Range boundaries.
    run_txn("t4.st_lo", 2'd2, 2'd2, 1'b0, 32'h00FF_FFFC, 32'h5555_AAAA, 5'd1, 0);
    run_txn("t4.ld_hi", 2'd1, 2'd2, 1'b0, 32'h010F_FFFE, 32'h0, 5'd2, 0);
    run_txn("t4.ld_top", 2'd1, 2'd2, 1'b0, 32'h010F_FFFC, 32'h0, 5'd2, 0);
    run_txn("t4.lb_last", 2'd1, 2'd0, 1'b1, 32'h010F_FFFF, 32'h0, 5'd2, 0);

    // Flush during a store's ACCESS: write commits, no response.
    @(negedge clock);
    drive(2'd2, 2'd2, 1'b0, 32'h0100_0040, 32'hCAFE_F00D, 5'd0, 32'h200);
    w0 = wr_count;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    flush = 1'b0;
    model_store(32'h0100_0040, 2'd2, 32'hCAFE_F00D);
    check("t5.fl_valid", 32'(out_valid), 32'd0);
    check("t5.fl_writes", 32'(wr_count - w0), 32'd1);
    check("t5.fl_mem", tb_word(32'h0100_0040), 32'hCAFE_F00D);
    @(negedge clock);
    check("t5.fl_idle_valid", 32'(out_valid), 32'd0);
    check("t5.fl_idle_ready", 32'(in_ready), 32'd1);

    // Flush in a load's RESP.
    drive(2'd1, 2'd2, 1'b0, 32'h0100_0040, 32'h0, 5'd9, 32'h204);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    check("t5.resp_valid", 32'(out_valid), 32'd1);
    check("t5.resp_result", out_result, 32'hCAFE_F00D);
    flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    flush = 1'b0;
    check("t5.resp_drop", 32'(out_valid), 32'd0);

    // Request alongside flush in IDLE is refused.
    drive(2'd0, 2'd0, 1'b0, 32'h7777_0000, 32'h0, 5'd1, 32'h208);
    flush = 1'b1;
    #1 check("t5.idle_flush_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; flush = 1'b0;
    check("t5.idle_flush_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    check("t5.idle_flush_valid2", 32'(out_valid), 32'd0);

    // Reset while a store is in ACCESS: no write.
    drive(2'd2, 2'd2, 1'b0, 32'h0100_0044, 32'h1122_3344, 5'd0, 32'h20C);
    w0 = wr_count;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    check("t5.pre_rst_rw", 32'(mem_read_write), 32'd1);
    reset_n = 1'b0;
    #1 check("t5.rst_rw", 32'(mem_read_write), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    check("t5.rst_writes", 32'(wr_count - w0), 32'd0);
    check("t5.rst_mem", tb_word(32'h0100_0044), ref_word(32'h0100_0044));
    check("t5.rst_valid", 32'(out_valid), 32'd0);

    // Misaligned half load.
    run_txn("t6.mis_h", 2'd1, 2'd1, 1'b0, 32'h0100_0001, 32'h0, 5'd6, 0);
    run_txn("t6.mis_w", 2'd2, 2'd2, 1'b0, 32'h0100_0082, 32'h0BAD_F00D, 5'd0, 0);

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom;
      else if (r == 1) a = MEM_BASE + MEM_DEPTH - 32'($urandom_range(1, 6));
      else if (r == 2) a = MEM_BASE - 32'($urandom_range(1, 4));
      else a = MEM_BASE + 32'($urandom_range(0, 1019));
      run_txn("rnd", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom),
              a, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
